// File: rtl/eth_rx_stream_pkg.sv
// Shared constants, FSM state type and the byte-wise CRC-32 step for the
// Ethernet receive stream.
package eth_rx_stream_pkg;

    localparam logic [7:0]  SFD         = 8'hD5;
    localparam int          FCS_BYTES   = 4;
    localparam int          DELAY_BYTES = FCS_BYTES + 1;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP,
        ST_DONE
    } rx_state_e;

    // Reflected CRC-32 update for one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc_gen2.sv
// Byte-wise Ethernet CRC-32; Crc_Out_o is the final complemented value and
// reflects a byte the cycle after Crc_En_i.
module eth_crc_gen2 import eth_rx_stream_pkg::*; (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init_i,
    input  logic        Crc_En_i,
    input  logic [7:0]  Data_i,
    output logic [31:0] Crc_Out_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (Init_i) begin
            crc_d = '1;
        end else if (Crc_En_i) begin
            crc_d = crc32_byte(crc_q, Data_i);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign Crc_Out_o = ~crc_q;

endmodule

// File: rtl/eth_rx_stream.sv
// MII/RMII receiver: SFD hunt, byte assembly, FCS strip via a 5-byte delay
// line, CRC check and per-frame status.
module eth_rx_stream import eth_rx_stream_pkg::*; #(
    parameter int pMII_WIDTH = 2,
    parameter int pMIN_FRAME = 64,
    parameter int pMAX_FRAME = 1518
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [pMII_WIDTH-1:0] Rxd,
    input  logic                  Rx_Dv,
    input  logic                  Rx_Er,
    output logic [7:0]            M_Data,
    output logic                  M_Valid,
    output logic                  M_Sof,
    output logic                  M_Last,
    output logic                  Frame_Done,
    output logic                  Crc_Valid,
    output logic                  Frame_Err,
    output logic [10:0]           Frame_Len,
    output logic                  Rx_Active
);

    generate
        if (!(pMII_WIDTH == 2 || pMII_WIDTH == 4)) begin : g_bad_width
            $error("eth_rx_stream: pMII_WIDTH must be 2 or 4");
        end
    endgenerate

    localparam logic [3:0]  BIT_STEP = 4'(pMII_WIDTH);
    localparam logic [3:0]  BIT_LAST = 4'(8 - pMII_WIDTH);
    localparam logic [10:0] MIN_LEN  = 11'(pMIN_FRAME);
    localparam logic [10:0] MAX_LEN  = 11'(pMAX_FRAME);
    localparam logic [10:0] SAT_LEN  = 11'(pMAX_FRAME + 1);
    localparam logic [2:0]  DL_FULL  = 3'(DELAY_BYTES);

    rx_state_e   state_q, state_d;
    logic [7:0]  win_q, win_d, byte_q, byte_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_done_q, byte_done_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  dl_q [DELAY_BYTES];
    logic [7:0]  dl_d [DELAY_BYTES];
    logic [2:0]  dl_cnt_q, dl_cnt_d;
    logic        sof_pend_q, sof_pend_d, misalign_q, misalign_d;
    logic        rxer_q, rxer_d, done_ph_q, done_ph_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_last_q, m_last_d;
    logic        frame_done_q, frame_done_d, crc_valid_q, crc_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [10:0] frame_len_q, frame_len_d;

    logic        emit, crc_init;
    logic [31:0] crc_out;
    logic [7:0]  win_nxt, byte_nxt;
    logic        oversize, held_full, crc_match;

    assign win_nxt   = {Rxd, win_q[7:pMII_WIDTH]};
    assign byte_nxt  = {Rxd, byte_q[7:pMII_WIDTH]};
    assign oversize  = byte_cnt_q > MAX_LEN;
    assign held_full = dl_cnt_q == DL_FULL;
    assign crc_match = crc_out == {dl_q[0], dl_q[1], dl_q[2], dl_q[3]};

    eth_crc_gen2 u_crc (
        .Clk       (Clk),
        .Rst       (Rst),
        .Init_i    (crc_init),
        .Crc_En_i  (emit),
        .Data_i    (dl_q[DELAY_BYTES-1]),
        .Crc_Out_o (crc_out)
    );

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        byte_d       = byte_q;
        bit_cnt_d    = bit_cnt_q;
        byte_done_d  = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        dl_d         = dl_q;
        dl_cnt_d     = dl_cnt_q;
        sof_pend_d   = sof_pend_q;
        misalign_d   = misalign_q;
        rxer_d       = rxer_q;
        done_ph_d    = done_ph_q;
        m_data_d     = m_data_q;
        m_valid_d    = 1'b0;
        m_sof_d      = 1'b0;
        m_last_d     = 1'b0;
        frame_done_d = 1'b0;
        crc_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        frame_len_d  = frame_len_q;
        emit         = 1'b0;
        crc_init     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                win_d = '0;
                if (Rx_Dv) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!Rx_Dv) begin
                    state_d = ST_IDLE;
                end else begin
                    win_d = win_nxt;
                    if (win_nxt == SFD) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        dl_cnt_d   = '0;
                        sof_pend_d = 1'b1;
                        misalign_d = 1'b0;
                        rxer_d     = 1'b0;
                        crc_init   = 1'b1;
                    end
                end
            end
            ST_DATA, ST_DROP: begin
                if (Rx_Er) rxer_d = 1'b1;
                if (Rx_Dv) begin
                    byte_d = byte_nxt;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d   = '0;
                        byte_done_d = 1'b1;
                        if (byte_cnt_q != SAT_LEN) byte_cnt_d = byte_cnt_q + 11'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_STEP;
                    end
                end
                // A byte completed last cycle enters the delay line, pushing out the oldest once full
                if (state_q == ST_DATA && byte_done_q) begin
                    for (int unsigned i = 1; i < DELAY_BYTES; i++) dl_d[i] = dl_q[i-1];
                    dl_d[0] = byte_q;
                    if (held_full) emit = 1'b1;
                    else           dl_cnt_d = dl_cnt_q + 3'd1;
                end
                if (!Rx_Dv) begin
                    state_d    = ST_DONE;
                    misalign_d = bit_cnt_q != '0;
                    done_ph_d  = 1'b0;
                end else if (state_q == ST_DATA && oversize) begin
                    state_d = ST_DROP;
                end
            end
            ST_DONE: begin
                if (!done_ph_q) begin
                    done_ph_d = 1'b1;
                    if (held_full && !oversize) begin
                        emit     = 1'b1;
                        m_last_d = 1'b1;
                    end
                end else begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    crc_valid_d  = held_full && !oversize && crc_match;
                    frame_err_d  = (byte_cnt_q < MIN_LEN) || oversize || misalign_q ||
                                   rxer_q || !held_full;
                    frame_len_d  = byte_cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            m_valid_d  = 1'b1;
            m_data_d   = dl_q[DELAY_BYTES-1];
            m_sof_d    = sof_pend_q;
            sof_pend_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            byte_q       <= '0;
            bit_cnt_q    <= '0;
            byte_done_q  <= 1'b0;
            byte_cnt_q   <= '0;
            for (int unsigned i = 0; i < DELAY_BYTES; i++) dl_q[i] <= '0;
            dl_cnt_q     <= '0;
            sof_pend_q   <= 1'b0;
            misalign_q   <= 1'b0;
            rxer_q       <= 1'b0;
            done_ph_q    <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            crc_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            byte_q       <= byte_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            byte_cnt_q   <= byte_cnt_d;
            dl_q         <= dl_d;
            dl_cnt_q     <= dl_cnt_d;
            sof_pend_q   <= sof_pend_d;
            misalign_q   <= misalign_d;
            rxer_q       <= rxer_d;
            done_ph_q    <= done_ph_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_sof_q      <= m_sof_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            crc_valid_q  <= crc_valid_d;
            frame_err_q  <= frame_err_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign M_Data     = m_data_q;
    assign M_Valid    = m_valid_q;
    assign M_Sof      = m_sof_q;
    assign M_Last     = m_last_q;
    assign Frame_Done = frame_done_q;
    assign Crc_Valid  = crc_valid_q;
    assign Frame_Err  = frame_err_q;
    assign Frame_Len  = frame_len_q;
    assign Rx_Active  = state_q inside {ST_PREAMBLE, ST_DATA, ST_DROP};

endmodule
